// File: rtl/divider_request_arbiter_if.sv
// Bundle of all request, response and divider-side signals of divider_request_arbiter.
// slave  : the arbiter's view (takes requests, drives responses and the divider).
// master : the surrounding environment's view (requesters, response sink, divider).
interface divider_request_arbiter_if #(
  parameter int numReq        = 4,
  parameter int dividendWidth = 10,
  parameter int divisorWidth  = 9,
  parameter int quotientWidth = 6,
  parameter int LODWidth      = 4
);
  localparam int idWidth = $clog2(numReq);

  logic [numReq-1:0]               req_valid;
  logic [numReq-1:0]               req_ready;
  logic [numReq*dividendWidth-1:0] req_dividend;
  logic [numReq*divisorWidth-1:0]  req_divisor;
  logic [numReq*LODWidth-1:0]      req_divisorLOD;

  logic                     resp_valid;
  logic                     resp_ready;
  logic [idWidth-1:0]       resp_id;
  logic [quotientWidth-1:0] resp_quotient;
  logic [dividendWidth-1:0] resp_remainder;
  logic                     resp_dbz;
  logic                     resp_timeout;

  logic                     div_start;
  logic [dividendWidth-1:0] div_dividend;
  logic [divisorWidth-1:0]  div_divisor;
  logic [LODWidth-1:0]      div_divisorLOD;
  logic                     div_ready;
  logic [quotientWidth-1:0] div_quotient;
  logic [dividendWidth-1:0] div_remainder;

  modport slave (
    input  req_valid, req_dividend, req_divisor, req_divisorLOD,
    output req_ready,
    output resp_valid, resp_id, resp_quotient, resp_remainder, resp_dbz, resp_timeout,
    input  resp_ready,
    output div_start, div_dividend, div_divisor, div_divisorLOD,
    input  div_ready, div_quotient, div_remainder
  );

  modport master (
    output req_valid, req_dividend, req_divisor, req_divisorLOD,
    input  req_ready,
    input  resp_valid, resp_id, resp_quotient, resp_remainder, resp_dbz, resp_timeout,
    output resp_ready,
    input  div_start, div_dividend, div_divisor, div_divisorLOD,
    output div_ready, div_quotient, div_remainder
  );
endinterface

// File: rtl/divider_request_arbiter.sv
// Round-robin arbiter sharing one sequential divider among numReq requesters.
// Accepts one request at a time, pulses div_start, waits for div_ready and holds
// the result until resp_ready. Zero divisors are answered directly (quotient all
// ones, remainder = dividend) without touching the divider.
// Optional macro DIV_TIMEOUT_EN adds a WAIT watchdog of timeoutCycles+1 cycles;
// without it WAIT is unbounded and resp_timeout is tied low.
module divider_request_arbiter #(
  parameter int numReq        = 4,
  parameter int dividendWidth = 10,
  parameter int divisorWidth  = 9,
  parameter int quotientWidth = 6,
  parameter int LODWidth      = 4
`ifdef DIV_TIMEOUT_EN
  , parameter int timeoutCycles = 15
`endif
) (
  input logic clk,
  input logic rst,
  divider_request_arbiter_if.slave bus
);
  localparam int idWidth = $clog2(numReq);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t state_reg, state_next;

  logic [idWidth-1:0]       rr_ptr_reg;
  logic [idWidth-1:0]       id_reg;
  logic [dividendWidth-1:0] dividend_reg;
  logic [divisorWidth-1:0]  divisor_reg;
  logic [LODWidth-1:0]      lod_reg;
  logic [quotientWidth-1:0] quotient_reg;
  logic [dividendWidth-1:0] remainder_reg;
  logic                     dbz_reg;

  logic [dividendWidth-1:0] dividend_arr [numReq];
  logic [divisorWidth-1:0]  divisor_arr  [numReq];
  logic [LODWidth-1:0]      lod_arr      [numReq];

  logic [idWidth-1:0] grant_id;
  logic               grant_found;
  logic               grant_dbz;
  logic [numReq-1:0]  req_ready_next;
  logic               div_start_next;
  logic               resp_valid_next;
  logic               wait_expired;

  // Unpack the flat request buses into per-requester operand arrays
  genvar gi;
  generate
    for (gi = 0; gi < numReq; gi++) begin : g_unpack
      assign dividend_arr[gi] = bus.req_dividend[gi*dividendWidth +: dividendWidth];
      assign divisor_arr[gi]  = bus.req_divisor[gi*divisorWidth +: divisorWidth];
      assign lod_arr[gi]      = bus.req_divisorLOD[gi*LODWidth +: LODWidth];
    end
  endgenerate

  // Round-robin pick: first valid requester at or after rr_ptr, wrapping at numReq
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int k = 0; k < numReq; k++) begin
      idx = (int'(rr_ptr_reg) + k) % numReq;
      if (!grant_found && bus.req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idWidth'(idx);
      end
    end
  end

  assign grant_dbz = (divisor_arr[grant_id] == '0);

`ifdef DIV_TIMEOUT_EN
  localparam int cntWidth = $clog2(timeoutCycles + 1);

  logic [cntWidth-1:0] wait_cnt_reg;
  logic                timeout_reg;

  assign wait_expired = (state_reg == WAIT) && !bus.div_ready &&
                        (wait_cnt_reg == cntWidth'(timeoutCycles));

  // Watchdog: counter restarts on entry to WAIT; flag set on expiry, cleared on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      if (state_reg == LOAD) begin
        wait_cnt_reg <= '0;
      end else if (state_reg == WAIT && !wait_expired) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end
      if (state_reg == IDLE && grant_found) begin
        timeout_reg <= 1'b0;
      end else if (wait_expired) begin
        timeout_reg <= 1'b1;
      end
    end
  end

  assign bus.resp_timeout = timeout_reg;
`else
  assign wait_expired     = 1'b0;
  assign bus.resp_timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // FSM next state and handshake outputs; req_ready is masked while rst is high
  always_comb begin
    state_next      = state_reg;
    req_ready_next  = '0;
    div_start_next  = 1'b0;
    resp_valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (grant_found && !rst) begin
          req_ready_next[grant_id] = 1'b1;
          state_next = grant_dbz ? RESP : LOAD;
        end
      end
      LOAD: begin
        div_start_next = 1'b1;
        state_next     = WAIT;
      end
      WAIT: begin
        if (bus.div_ready || wait_expired) state_next = RESP;
      end
      RESP: begin
        resp_valid_next = 1'b1;
        if (bus.resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture on accept, result capture in WAIT, pointer advance on response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      id_reg        <= '0;
      dividend_reg  <= '0;
      divisor_reg   <= '0;
      lod_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            id_reg       <= grant_id;
            dividend_reg <= dividend_arr[grant_id];
            divisor_reg  <= divisor_arr[grant_id];
            lod_reg      <= lod_arr[grant_id];
            dbz_reg      <= grant_dbz;
            if (grant_dbz) begin
              quotient_reg  <= '1;
              remainder_reg <= dividend_arr[grant_id];
            end
          end
        end
        WAIT: begin
          if (bus.div_ready || wait_expired) begin
            quotient_reg  <= bus.div_quotient;
            remainder_reg <= bus.div_remainder;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            rr_ptr_reg <= (id_reg == idWidth'(numReq - 1)) ? '0 : id_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready      = req_ready_next;
  assign bus.div_start      = div_start_next;
  assign bus.resp_valid     = resp_valid_next;
  assign bus.resp_id        = id_reg;
  assign bus.resp_quotient  = quotient_reg;
  assign bus.resp_remainder = remainder_reg;
  assign bus.resp_dbz       = dbz_reg;
  assign bus.div_dividend   = dividend_reg;
  assign bus.div_divisor    = divisor_reg;
  assign bus.div_divisorLOD = lod_reg;
endmodule

// File: tb/tb_divider_request_arbiter.sv
// Directed bench for divider_request_arbiter with a small behavioural divider.
// The divider model takes divisorLOD[1:0] iterations; result latency from the
// accept cycle is therefore 4 + divisorLOD[1:0] cycles. Build with
// +define+DIV_TIMEOUT_EN to exercise the watchdog.
module tb_divider_request_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  divider_request_arbiter_if #(.numReq(4), .dividendWidth(10), .divisorWidth(9),
                               .quotientWidth(6), .LODWidth(4)) bus ();

  divider_request_arbiter #(.numReq(4), .dividendWidth(10), .divisorWidth(9),
                            .quotientWidth(6), .LODWidth(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural divider: loads on div_start, counts down, pulses div_ready for one cycle
  logic       hold  = 1'b0;
  logic       mbusy = 1'b0;
  logic [1:0] mcnt  = 2'd0;
  always @(posedge clk) begin
    bus.div_ready <= 1'b0;
    if (bus.div_start) begin
      mbusy             <= 1'b1;
      mcnt              <= bus.div_divisorLOD[1:0];
      bus.div_quotient  <= 6'(10'(bus.div_dividend / 10'(bus.div_divisor)));
      bus.div_remainder <= 10'(bus.div_dividend % 10'(bus.div_divisor));
    end else if (mbusy && !hold) begin
      if (mcnt == 2'd0) begin
        bus.div_ready <= 1'b1;
        mbusy         <= 1'b0;
      end else begin
        mcnt <= mcnt - 2'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [9:0] dd, input logic [8:0] dv,
                         input logic [3:0] lod);
    bus.req_dividend[i*10 +: 10] = dd;
    bus.req_divisor[i*9 +: 9]    = dv;
    bus.req_divisorLOD[i*4 +: 4] = lod;
    bus.req_valid[i]             = 1'b1;
  endtask

  // Wait for a grant, let it transfer, then count cycles until resp_valid.
  // lat = 1 in the cycle right after the accept cycle.
  task automatic serve(input string tag, input int exp_grant, input int exp_lat,
                       input logic [5:0] exp_q, input logic [9:0] exp_r,
                       input logic exp_dbz, input logic exp_to,
                       input int release_at, input logic ack);
    int waitc = 0;
    int g = -1;
    int lat;
    int starts;
    #1;
    while (bus.req_ready == 4'b0 && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    for (int i = 0; i < 4; i++) if (bus.req_ready[i]) g = i;
    chk({tag, " grant"}, g, exp_grant);
    chk({tag, " onehot"}, $countones(bus.req_ready), 1);
    @(posedge clk); #1;
    if (g >= 0) bus.req_valid[g] = 1'b0;
    chk({tag, " ready_busy"}, bus.req_ready, 4'b0);
    lat    = 1;
    starts = bus.div_start ? 1 : 0;
    while (!bus.resp_valid && lat < 80) begin
      if (lat == release_at) hold = 1'b0;
      @(posedge clk); #1;
      lat++;
      if (bus.div_start) starts++;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " id"}, bus.resp_id, exp_grant);
    chk({tag, " quot"}, bus.resp_quotient, exp_q);
    chk({tag, " rem"}, bus.resp_remainder, exp_r);
    chk({tag, " dbz"}, bus.resp_dbz, exp_dbz);
    chk({tag, " timeout"}, bus.resp_timeout, exp_to);
    chk({tag, " starts"}, starts, exp_dbz ? 0 : 1);
    if (ack) begin
      bus.resp_ready = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready = 1'b0;
      chk({tag, " resp_drop"}, bus.resp_valid, 1'b0);
    end
  endtask

  initial begin
    bus.req_valid      = '0;
    bus.req_dividend   = '0;
    bus.req_divisor    = '0;
    bus.req_divisorLOD = '0;
    bus.resp_ready     = 1'b0;

    // Reset state, with a request already pending
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 10'd100, 9'd7, 4'd2);
    #1;
    chk("rst req_ready", bus.req_ready, 4'b0);
    chk("rst resp_valid", bus.resp_valid, 1'b0);
    chk("rst div_start", bus.div_start, 1'b0);
    chk("rst resp_id", bus.resp_id, 0);
    chk("rst quot", bus.resp_quotient, 0);
    chk("rst rem", bus.resp_remainder, 0);
    chk("rst dbz", bus.resp_dbz, 1'b0);
    chk("rst timeout", bus.resp_timeout, 1'b0);
    chk("rst div_dividend", bus.div_dividend, 0);
    rst = 1'b0;

    // 1: single request 100/7 (LOD 2 -> 2 iterations)
    serve("t1", 0, 6, 6'd14, 10'd2, 1'b0, 1'b0, 0, 1'b1);

    // 2: four simultaneous requests from a fresh pointer, then wrap back to 0
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 10'd100, 9'd7, 4'd2);
    set_req(1, 10'd200, 9'd9, 4'd3);
    set_req(2, 10'd1000, 9'd31, 4'd4);
    set_req(3, 10'd63, 9'd8, 4'd3);
    serve("t2a", 0, 6, 6'd14, 10'd2, 1'b0, 1'b0, 0, 1'b1);
    serve("t2b", 1, 7, 6'd22, 10'd2, 1'b0, 1'b0, 0, 1'b1);
    serve("t2c", 2, 4, 6'd32, 10'd8, 1'b0, 1'b0, 0, 1'b1);
    serve("t2d", 3, 7, 6'd7, 10'd7, 1'b0, 1'b0, 0, 1'b1);
    set_req(1, 10'd200, 9'd9, 4'd3);
    set_req(0, 10'd100, 9'd7, 4'd2);
    serve("t2e", 0, 6, 6'd14, 10'd2, 1'b0, 1'b0, 0, 1'b1);
    serve("t2f", 1, 7, 6'd22, 10'd2, 1'b0, 1'b0, 0, 1'b1);

    // 3: divide by zero answered next cycle without the divider
    set_req(2, 10'd55, 9'd0, 4'd0);
    serve("t3", 2, 1, 6'd63, 10'd55, 1'b1, 1'b0, 0, 1'b1);

    // 4: response back-pressure; req0 waits behind req3
    set_req(3, 10'd50, 9'd5, 4'd2);
    set_req(0, 10'd100, 9'd7, 4'd2);
    serve("t4", 3, 6, 6'd10, 10'd0, 1'b0, 1'b0, 0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("t4 hold valid", bus.resp_valid, 1'b1);
      chk("t4 hold quot", bus.resp_quotient, 6'd10);
      chk("t4 hold rem", bus.resp_remainder, 10'd0);
      chk("t4 hold id", bus.resp_id, 3);
      chk("t4 hold req_ready", bus.req_ready, 4'b0);
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("t4 resp_drop", bus.resp_valid, 1'b0);
    serve("t4b", 0, 6, 6'd14, 10'd2, 1'b0, 1'b0, 0, 1'b1);

    // 5: asynchronous reset while in WAIT, then a fresh request
    set_req(1, 10'd90, 9'd9, 4'd3);
    #1;
    chk("t5 grant", bus.req_ready, 4'b0010);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("t5 operand", bus.div_dividend, 10'd90);
    set_req(2, 10'd55, 9'd3, 4'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5 rst resp_valid", bus.resp_valid, 1'b0);
    chk("t5 rst div_start", bus.div_start, 1'b0);
    chk("t5 rst div_dividend", bus.div_dividend, 0);
    chk("t5 rst div_divisor", bus.div_divisor, 0);
    chk("t5 rst req_ready", bus.req_ready, 4'b0);
    @(posedge clk); #1;
    chk("t5 rst held req_ready", bus.req_ready, 4'b0);
    bus.req_valid = '0;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    set_req(1, 10'd90, 9'd9, 4'd3);
    serve("t5b", 1, 7, 6'd10, 10'd0, 1'b0, 1'b0, 0, 1'b1);

    // 6: divider stalls (300/17 = 17 r 11)
    set_req(0, 10'd300, 9'd17, 4'd4);
    hold = 1'b1;
`ifdef DIV_TIMEOUT_EN
    serve("t6", 0, 18, 6'd17, 10'd11, 1'b0, 1'b1, 0, 1'b1);
    hold = 1'b0;
    repeat (4) @(posedge clk);
    #1;
`else
    serve("t6", 0, 42, 6'd17, 10'd11, 1'b0, 1'b0, 40, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
